imem_access_arbiter: RTL and testbench

//  Shares the single read port of program_memory between the core fetch unit and the debug read port.
//  - Sits between the fetch stage/debug block and program_memory; drives program_memory.pc and captures instr_out.
//  - Fixed priority to fetch, with a starvation guard for debug.
//  - Response is registered: data returns exactly 1 cycle after grant.

---
 rtl/imem_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_imem_access_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares the program_memory read port between fetch and debug.
// Fetch has fixed priority, and a starvation guard forces a debug grant. Define ARB_PERF_COUNTERS_EN to add grant/stall counters.
module imem_access_arbiter #(
  parameter int unsigned DEPTH        = 32'd32,
  parameter int unsigned STARVE_LIMIT = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        last_gnt
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0] f_gnt_cnt,
  output logic [31:0] d_gnt_cnt,
  output logic [31:0] d_stall_cnt
`endif
);

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DEBUG = 1'b1
  } gnt_side_e;

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [31:0] DEPTH_W    = 32'(DEPTH);

  // The full 32-bit word index is compared so that high addresses cannot alias back into range.
  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH_W);
  endfunction

  logic [3:0]  starve_cnt_r;
  gnt_side_e   last_gnt_r;
  logic        starved_s;
  logic        f_gnt_s;
  logic        d_gnt_s;
  logic [31:0] gnt_addr_s;
  logic        gnt_err_s;
  logic [31:0] gnt_rdata_s;

  // Grant decision and granted-address datapath
  always_comb begin
    starved_s   = (starve_cnt_r == STARVE_MAX);
    f_gnt_s     = 1'b0;
    d_gnt_s     = 1'b0;
    gnt_addr_s  = 32'h0000_0000;
    case ({f_req, d_req})
      2'b10:   f_gnt_s = 1'b1;
      2'b01:   d_gnt_s = 1'b1;
      2'b11: begin
        if (starved_s) begin
          d_gnt_s = 1'b1;
        end else begin
          f_gnt_s = 1'b1;
        end
      end
      default: begin
        f_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
      end
    endcase
    if (d_gnt_s) begin
      gnt_addr_s = d_addr;
    end else if (f_gnt_s) begin
      gnt_addr_s = f_addr;
    end else begin
      gnt_addr_s = 32'h0000_0000;
    end
    gnt_err_s   = addr_err(gnt_addr_s);
    gnt_rdata_s = gnt_err_s ? 32'h0000_0000 : mem_rdata;
  end

  assign f_gnt    = f_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign mem_addr = gnt_addr_s;
  assign last_gnt = last_gnt_r;

  // Registered responses, starvation counter and last-grant tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rvalid     <= 1'b0;
      f_rdata      <= 32'h0000_0000;
      f_err        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= 32'h0000_0000;
      d_err        <= 1'b0;
      starve_cnt_r <= 4'd0;
      last_gnt_r   <= GNT_FETCH;
    end else begin
      f_rvalid <= f_gnt_s;
      d_rvalid <= d_gnt_s;
      f_err    <= f_gnt_s & gnt_err_s;
      d_err    <= d_gnt_s & gnt_err_s;
      if (f_gnt_s) begin
        f_rdata <= gnt_rdata_s;
      end
      if (d_gnt_s) begin
        d_rdata    <= gnt_rdata_s;
        last_gnt_r <= GNT_DEBUG;
      end else if (f_gnt_s) begin
        last_gnt_r <= GNT_FETCH;
      end
      // Saturating count of consecutive denied debug cycles
      if (d_req && !d_gnt_s) begin
        if (!starved_s) begin
          starve_cnt_r <= starve_cnt_r + 4'd1;
        end
      end else begin
        starve_cnt_r <= 4'd0;
      end
    end
  end

`ifdef ARB_PERF_COUNTERS_EN
  // Free-running performance counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      f_gnt_cnt   <= 32'd0;
      d_gnt_cnt   <= 32'd0;
      d_stall_cnt <= 32'd0;
    end else begin
      if (f_gnt_s) begin
        f_gnt_cnt <= f_gnt_cnt + 32'd1;
      end
      if (d_gnt_s) begin
        d_gnt_cnt <= d_gnt_cnt + 32'd1;
      end
      if (d_req && !d_gnt_s) begin
        d_stall_cnt <= d_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed self-checking bench for imem_access_arbiter (DEPTH=32, STARVE_LIMIT=4).
// Counter checks run only when ARB_PERF_COUNTERS_EN is defined.
module tb_imem_access_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        last_gnt;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] f_gnt_cnt;
  logic [31:0] d_gnt_cnt;
  logic [31:0] d_stall_cnt;
`endif

  int          checks;
  int          failures;
  logic [31:0] rom [32];
  logic [31:0] s4_addr [5];
  logic        s4_err [5];
  logic        exp_d;

  imem_access_arbiter #(.DEPTH(32), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .last_gnt  (last_gnt)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .f_gnt_cnt   (f_gnt_cnt),
    .d_gnt_cnt   (d_gnt_cnt),
    .d_stall_cnt (d_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model; out-of-range reads return a marker the DUT must never forward.
  assign mem_rdata = (mem_addr < 32'h80) ? rom[mem_addr[6:2]] : 32'hDEAD_BEEF;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) rom[i] = {16'hC0DE, 8'(i), 8'(8'd255 - 8'(i))};
    rom[2] = 32'h0050_0093;
    s4_addr[0] = 32'h0000_0082; s4_err[0] = 1'b1;
    s4_addr[1] = 32'h0000_0080; s4_err[1] = 1'b1;
    s4_addr[2] = 32'h0000_007C; s4_err[2] = 1'b0;
    s4_addr[3] = 32'h0000_0006; s4_err[3] = 1'b1;
    s4_addr[4] = 32'hFFFF_FFFC; s4_err[4] = 1'b1;

    // Step 1: requests held during reset produce no response
    rst = 1'b1; f_req = 1'b1; d_req = 1'b1; f_addr = 32'h8; d_addr = 32'h4;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
    #1;
    chk1("rst_f_rvalid", f_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk32("rst_f_rdata", f_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_f_err", f_err, 1'b0);
    chk1("rst_d_err", d_err, 1'b0);
    chk1("rst_last_gnt", last_gnt, 1'b0);

    // Step 2: single fetch of word 2
    f_req = 1'b1; f_addr = 32'h8;
    #1;
    chk1("s2_f_gnt", f_gnt, 1'b1);
    chk1("s2_d_gnt", d_gnt, 1'b0);
    chk32("s2_mem_addr", mem_addr, 32'h8);
    @(posedge clk); #1;
    chk1("s2_f_rvalid", f_rvalid, 1'b1);
    chk32("s2_f_rdata", f_rdata, 32'h0050_0093);
    chk1("s2_f_err", f_err, 1'b0);
    chk1("s2_d_rvalid", d_rvalid, 1'b0);
    f_req = 1'b0;
    @(posedge clk); #1;
    chk1("s2_pulse_end", f_rvalid, 1'b0);
    chk32("s2_rdata_hold", f_rdata, 32'h0050_0093);
    chk32("s2_idle_mem_addr", mem_addr, 32'h0);

    // Reset pulse so the counters start from zero for the arbitration run
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk32("rst2_f_rdata", f_rdata, 32'h0);

    // Step 3: both requesting continuously -> F,F,F,F,D repeating
    f_req = 1'b1; d_req = 1'b1; f_addr = 32'h10; d_addr = 32'h14;
    for (int i = 0; i < 10; i++) begin
      exp_d = ((i % 5) == 4);
      #1;
      chk1("s3_f_gnt", f_gnt, !exp_d);
      chk1("s3_d_gnt", d_gnt, exp_d);
      chk32("s3_mem_addr", mem_addr, exp_d ? 32'h14 : 32'h10);
      @(posedge clk); #1;
      chk1("s3_f_rvalid", f_rvalid, !exp_d);
      chk1("s3_d_rvalid", d_rvalid, exp_d);
      chk1("s3_last_gnt", last_gnt, exp_d);
      if (exp_d) chk32("s3_d_rdata", d_rdata, rom[5]);
      else       chk32("s3_f_rdata", f_rdata, rom[4]);
    end
`ifdef ARB_PERF_COUNTERS_EN
    chk32("cnt_f_gnt", f_gnt_cnt, 32'd8);
    chk32("cnt_d_gnt", d_gnt_cnt, 32'd2);
    chk32("cnt_d_stall", d_stall_cnt, 32'd8);
`endif
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Step 4: debug-only address boundaries, back-to-back
    d_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d_addr = s4_addr[i];
      #1;
      chk1("s4_d_gnt", d_gnt, 1'b1);
      @(posedge clk); #1;
      chk1("s4_d_rvalid", d_rvalid, 1'b1);
      chk1("s4_d_err", d_err, s4_err[i]);
      chk32("s4_d_rdata", d_rdata, s4_err[i] ? 32'h0 : rom[31]);
    end
    d_req = 1'b0;
    @(posedge clk); #1;
    chk1("s4_pulse_end", d_rvalid, 1'b0);

    // Step 5: eight back-to-back fetches of words 0..7
    f_req = 1'b1; f_addr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk1("s5_f_rvalid", f_rvalid, 1'b1);
      chk32("s5_f_rdata", f_rdata, rom[i]);
      chk1("s5_f_err", f_err, 1'b0);
      if (i < 7) f_addr = 32'(4 * (i + 1));
      else       f_addr = 32'h1E;
    end
    @(posedge clk); #1;
    chk1("s5_mis_f_err", f_err, 1'b1);
    chk32("s5_mis_f_rdata", f_rdata, 32'h0);
    f_req = 1'b0;
    @(posedge clk); #1;
    chk1("s5_pulse_end", f_rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
